spi_ram_host_ctrl: RTL

SPI_RAM_HOST_CTRL -- requirements
Module: spi_ram_host_ctrl

---
 rtl/spi_ram_host_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_ram_host_ctrl.sv
// SPI RAM host controller: turns one read/write request into a two-frame
// 10-bit SPI exchange (address frame, then data frame), optionally receives
// a byte back, and reports completion with a one-cycle rsp_valid pulse.
//
// Handshake: a request is accepted in the cycle where req_valid && req_ready;
// req_ready is high only in IDLE, req_wr/req_addr/req_wdata are captured on
// that edge and ignored afterwards; rsp_valid is a single-cycle pulse with
// rsp_rdata held stable until the next completion.
module spi_ram_host_ctrl #(
  parameter int GAP     = 1,
  parameter int RD_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       ss_n,
  output logic       mosi,
  input  logic       miso,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT0 = 3'd1,
    GAP0   = 3'd2,
    SHIFT1 = 3'd3,
    WAIT   = 3'd4,
    RECV   = 3'd5,
    GAP1   = 3'd6
  } state_t;

  // Down-counter must hold the longest phase length minus one.
  localparam int M1 = (GAP > 10) ? GAP : 10;
  localparam int M2 = (RD_WAIT > M1) ? RD_WAIT : M1;
  localparam int CW = $clog2(M2);

  localparam logic [CW-1:0] FRAME_LAST = CW'(9);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] RECV_LAST  = CW'(7);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          mosi_q, mosi_d;
  logic [7:0]    rx_q, rx_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;

  logic [9:0]    frame0;
  logic [9:0]    frame1;
  logic [3:0]    bit_idx;

  assign frame0  = {(wr_q ? 2'b00 : 2'b10), addr_q};
  assign frame1  = wr_q ? {2'b01, wdata_q} : {2'b11, 8'h00};
  // Index of the frame bit to present in the next SHIFT cycle.
  assign bit_idx = cnt_q[3:0] - 4'd1;

  // State, counter, capture, serial and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      mosi_q      <= 1'b0;
      rx_q        <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mosi_q      <= mosi_d;
      rx_q        <= rx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next-state and datapath: each phase loads cnt with its length minus one
  // and leaves when cnt reaches zero; mosi is set one cycle ahead.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mosi_d      = 1'b0;
    rx_d        = rx_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SHIFT0;
          cnt_d   = FRAME_LAST;
          wr_d    = req_wr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          // Bit 9 of the address frame is cmd[1]: 0 for write, 1 for read.
          mosi_d  = ~req_wr;
        end
      end
      SHIFT0: begin
        if (cnt_q == '0) begin
          state_d = GAP0;
          cnt_d   = GAP_LAST;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          mosi_d = frame0[bit_idx];
        end
      end
      GAP0: begin
        if (cnt_q == '0) begin
          state_d = SHIFT1;
          cnt_d   = FRAME_LAST;
          mosi_d  = frame1[9];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SHIFT1: begin
        if (cnt_q == '0) begin
          state_d = wr_q ? GAP1 : WAIT;
          cnt_d   = wr_q ? GAP_LAST : WAIT_LAST;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          mosi_d = frame1[bit_idx];
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RECV;
          cnt_d   = RECV_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RECV: begin
        rx_d = {rx_q[6:0], miso};
        if (cnt_q == '0) begin
          state_d = GAP1;
          cnt_d   = GAP_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP1: begin
        if (cnt_q == '0) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wr_q ? 8'h00 : rx_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  // Decoded straight from the state flop so reset raises ss_n at once.
  assign ss_n      = !((state_q == SHIFT0) || (state_q == SHIFT1) ||
                       (state_q == WAIT)   || (state_q == RECV));
  assign mosi      = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
